// File: rtl/dbus_sram_responder.sv
// -----------------------------------------------------------------------------
// dbus_sram_responder
//
// Responder end of the cache data bus. Models a word-addressed scratchpad with
// a fixed response latency and an in-order queue of accepted-but-unanswered
// requests.
//
// Handshake: a request transfers on a rising edge where dbus_valid and
// dbus_addr_ok are both high. dbus_addr_ok depends only on queue occupancy
// (never on dbus_valid), so the requester may raise or drop dbus_valid freely.
// Every accepted request, read or write, is answered by exactly one
// single-cycle dbus_data_ok pulse, strictly in acceptance order. There is no
// back-pressure on the response side.
//
// Ports
//   clk           in   1   clock, all state on rising edge
//   resetn        in   1   asynchronous active-low reset
//   dbus_valid    in   1   request valid
//   dbus_address  in   32  byte address; word index = address[AW+1:2]
//   dbus_size     in   2   informational only (wstrb is authoritative)
//   dbus_op       in   1   0 = read, 1 = write
//   dbus_wstrb    in   4   byte enables for writes
//   dbus_wdata    in   32  write data
//   dbus_uncache  in   1   ignored, target always behaves uncached
//   dbus_addr_ok  out  1   request accepted when dbus_valid && dbus_addr_ok
//   dbus_data_ok  out  1   one-cycle pulse: queue head complete
//   dbus_rdata    out  32  head read data while dbus_data_ok for a read, else 0
// -----------------------------------------------------------------------------
module dbus_sram_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 2,
  parameter int QDEPTH      = 4
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        dbus_valid,
  input  logic [31:0] dbus_address,
  input  logic [1:0]  dbus_size,
  input  logic        dbus_op,
  input  logic [3:0]  dbus_wstrb,
  input  logic [31:0] dbus_wdata,
  input  logic        dbus_uncache,
  output logic        dbus_addr_ok,
  output logic        dbus_data_ok,
  output logic [31:0] dbus_rdata
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam int QW = $clog2(QDEPTH);
  // Timer only ever holds values 0..LATENCY-1.
  localparam int TW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  localparam logic [TW-1:0] TIMER_LOAD = TW'(LATENCY - 1);
  localparam logic [QW:0]   COUNT_FULL = (QW + 1)'(QDEPTH);
  localparam logic [QW:0]   COUNT_ONE  = (QW + 1)'(1);

  // Control state (reset)
  logic [QW:0]   count_q, count_d;
  logic [QW-1:0] wptr_q, wptr_d;
  logic [QW-1:0] rptr_q, rptr_d;
  logic [TW-1:0] timer_q, timer_d;

  // Storage (not reset)
  logic [31:0] mem_q    [DEPTH_WORDS];
  logic        q_op_q   [QDEPTH];
  logic [31:0] q_data_q [QDEPTH];

  logic [AW-1:0] word_idx;
  logic          push;
  logic          pop;

  // Upper address bits are dropped so out-of-range addresses alias (wrap).
  assign word_idx = dbus_address[AW+1:2];

  // Inputs that carry no information for this target.
  logic unused_inputs;
  assign unused_inputs = ^{dbus_size, dbus_uncache,
                           dbus_address[31:AW+2], dbus_address[1:0]};

  // Accept is based on the registered count only: a pop in the same cycle
  // does not open a slot until the next cycle.
  assign dbus_addr_ok = resetn && (count_q < COUNT_FULL);
  assign dbus_data_ok = (count_q != '0) && (timer_q == '0);
  assign dbus_rdata   = (dbus_data_ok && !q_op_q[rptr_q]) ? q_data_q[rptr_q] : 32'h0;

  assign push = dbus_valid && dbus_addr_ok;
  assign pop  = dbus_data_ok;

  always_comb begin
    count_d = count_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    timer_d = timer_q;

    if (push) wptr_d = wptr_q + QW'(1);
    if (pop)  rptr_d = rptr_q + QW'(1);

    case ({push, pop})
      2'b10:   count_d = count_q + COUNT_ONE;
      2'b01:   count_d = count_q - COUNT_ONE;
      default: count_d = count_q;
    endcase

    // A new head (push into empty, or pop leaving something behind, including
    // the entry pushed this very edge) restarts the latency countdown.
    if (push && (count_q == '0)) begin
      timer_d = TIMER_LOAD;
    end else if (pop && ((count_q > COUNT_ONE) || push)) begin
      timer_d = TIMER_LOAD;
    end else if (timer_q != '0) begin
      timer_d = timer_q - TW'(1);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      count_q <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      timer_q <= '0;
    end else begin
      count_q <= count_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      timer_q <= timer_d;
    end
  end

  // Memory is accessed at the accept edge: reads snapshot the word into the
  // queue entry, writes merge enabled bytes. A later read therefore sees an
  // earlier write even before that write's data_ok has been returned.
  always_ff @(posedge clk) begin
    if (push) begin
      q_op_q[wptr_q]   <= dbus_op;
      q_data_q[wptr_q] <= dbus_op ? 32'h0 : mem_q[word_idx];
      if (dbus_op) begin
        for (int b = 0; b < 4; b++) begin
          if (dbus_wstrb[b]) mem_q[word_idx][8*b +: 8] <= dbus_wdata[8*b +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_dbus_sram_responder.sv
// -----------------------------------------------------------------------------
// tb_dbus_sram_responder
//
// Three responders (LATENCY 2, 3, 1; QDEPTH 4; 1024 words) share one request
// stream. Each has its own reference model: a word array for memory and a
// queue of expected responses, each tagged with the cycle its data_ok is due.
// Due cycle of a request accepted at edge T is
//   max(T, due cycle of the previous request + 1) + LATENCY - 1
// and addr_ok is expected whenever fewer than QDEPTH responses are owed.
// -----------------------------------------------------------------------------
module tb_dbus_sram_responder;

  localparam int NI = 3;
  localparam int QD = 4;

  function automatic int lat_of(input int i);
    return (i == 0) ? 2 : ((i == 1) ? 3 : 1);
  endfunction

  // Clock / reset
  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Shared request bus
  logic        dbus_valid;
  logic [31:0] dbus_address;
  logic [1:0]  dbus_size;
  logic        dbus_op;
  logic [3:0]  dbus_wstrb;
  logic [31:0] dbus_wdata;
  logic        dbus_uncache;

  logic        aok [NI];
  logic        dok [NI];
  logic [31:0] rd  [NI];

  for (genvar g = 0; g < NI; g++) begin : g_inst
    dbus_sram_responder #(
      .DEPTH_WORDS(1024),
      .LATENCY    (lat_of(g)),
      .QDEPTH     (QD)
    ) u_dut (
      .clk         (clk),
      .resetn      (resetn),
      .dbus_valid  (dbus_valid),
      .dbus_address(dbus_address),
      .dbus_size   (dbus_size),
      .dbus_op     (dbus_op),
      .dbus_wstrb  (dbus_wstrb),
      .dbus_wdata  (dbus_wdata),
      .dbus_uncache(dbus_uncache),
      .dbus_addr_ok(aok[g]),
      .dbus_data_ok(dok[g]),
      .dbus_rdata  (rd[g])
    );
  end

  // Scoreboard
  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] mem_m    [NI][1024];
  logic [31:0] exp_q    [NI][$];
  int          doc_q    [NI][$];
  int          last_doc [NI];

  initial for (int i = 0; i < NI; i++) last_doc[i] = -1000;

  always @(negedge clk) begin : model
    logic        exp_aok;
    logic        exp_dok;
    logic [31:0] exp_rd;
    logic [31:0] w;
    int          idx;
    int          head_edge;
    int          doc;
    for (int i = 0; i < NI; i++) begin
      if (resetn !== 1'b1) begin
        exp_q[i].delete();
        doc_q[i].delete();
        last_doc[i] = -1000;
      end
      exp_aok = (resetn === 1'b1) && (exp_q[i].size() < QD);
      exp_dok = 1'b0;
      exp_rd  = 32'h0;
      if (doc_q[i].size() > 0) begin
        if (doc_q[i][0] == cyc) begin
          exp_dok = 1'b1;
          exp_rd  = exp_q[i][0];
        end
      end

      n_cmp++;
      assert (aok[i] === exp_aok) else begin
        n_err++;
        $error("FAIL addr_ok inst=%0d cyc=%0d got=%b exp=%b", i, cyc, aok[i], exp_aok);
      end
      n_cmp++;
      assert (dok[i] === exp_dok) else begin
        n_err++;
        $error("FAIL data_ok inst=%0d cyc=%0d got=%b exp=%b", i, cyc, dok[i], exp_dok);
      end
      n_cmp++;
      assert (rd[i] === exp_rd) else begin
        n_err++;
        $error("FAIL rdata inst=%0d cyc=%0d got=%h exp=%h", i, cyc, rd[i], exp_rd);
      end

      if (exp_dok) begin
        void'(exp_q[i].pop_front());
        void'(doc_q[i].pop_front());
      end

      if ((dbus_valid === 1'b1) && exp_aok) begin
        idx       = int'((dbus_address / 4) % 1024);
        head_edge = (cyc + 1 > last_doc[i] + 1) ? cyc + 1 : last_doc[i] + 1;
        doc       = head_edge + lat_of(i) - 1;
        last_doc[i] = doc;
        if (dbus_op) begin
          w = mem_m[i][idx];
          for (int b = 0; b < 4; b++) begin
            if (dbus_wstrb[b]) w[8*b +: 8] = dbus_wdata[8*b +: 8];
          end
          mem_m[i][idx] = w;
          exp_q[i].push_back(32'h0);
        end else begin
          exp_q[i].push_back(mem_m[i][idx]);
        end
        doc_q[i].push_back(doc);
      end
    end
  end

  // Driver tasks
  task automatic drive(input logic v, input logic op, input logic [31:0] a,
                       input logic [3:0] s, input logic [31:0] d);
    dbus_valid   = v;
    dbus_op      = op;
    dbus_address = a;
    dbus_wstrb   = s;
    dbus_wdata   = d;
    dbus_size    = 2'($urandom_range(0, 2));
    dbus_uncache = 1'($urandom_range(0, 1));
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 1'($urandom_range(0, 1)), $urandom, 4'($urandom_range(0, 15)), $urandom);
  endtask

  // Word 0..15 with random bits above the 1024-word range, so wrap is exercised.
  function automatic logic [31:0] rand_addr(input int w);
    logic [31:0] r;
    r = $urandom;
    return (r & 32'hFFFF_F000) | (32'(w) << 2) | (r & 32'h3);
  endfunction

  // Stimulus
  initial begin
    resetn       = 1'b0;
    dbus_valid   = 1'b0;
    dbus_op      = 1'b0;
    dbus_address = 32'h0;
    dbus_wstrb   = 4'h0;
    dbus_wdata   = 32'h0;
    dbus_size    = 2'd2;
    dbus_uncache = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    resetn = 1'b1;
    idle(2);

    // Fill words 0..15, spaced so every instance accepts every write.
    for (int w = 0; w < 16; w++) begin
      drive(1'b1, 1'b1, 32'(w) << 2, 4'hF, $urandom);
      idle(3);
    end

    // Full-word write then read of the same address.
    drive(1'b1, 1'b1, 32'h10, 4'hF, 32'hDEADBEEF);
    drive(1'b1, 1'b0, 32'h10, 4'h0, 32'h0);
    idle(6);

    // Single-byte merge.
    drive(1'b1, 1'b1, 32'h10, 4'b0010, 32'h0000AB00);
    drive(1'b1, 1'b0, 32'h10, 4'h0, 32'h0);
    idle(6);

    // Valid held high on a read stream: queues fill and stall.
    for (int i = 0; i < 10; i++) drive(1'b1, 1'b0, 32'((i % 6) * 4), 4'h0, 32'h0);
    idle(8);

    // Continuous reads of consecutive words.
    for (int i = 0; i < 12; i++) drive(1'b1, 1'b0, 32'(i * 4), 4'h0, 32'h0);
    idle(6);

    // Address wrap: 0x1000 aliases word 0.
    drive(1'b1, 1'b1, 32'h1000, 4'hF, 32'hCAFEF00D);
    drive(1'b1, 1'b0, 32'h0, 4'h0, 32'h0);
    idle(6);

    // Random traffic.
    repeat (400) begin
      if ($urandom_range(0, 9) < 7)
        drive(1'b1, 1'($urandom_range(0, 1)), rand_addr($urandom_range(0, 15)),
              4'($urandom_range(0, 15)), $urandom);
      else
        idle(1);
    end
    idle(8);

    // Reset with requests outstanding; memory must survive.
    drive(1'b1, 1'b0, 32'h4, 4'h0, 32'h0);
    drive(1'b1, 1'b0, 32'h8, 4'h0, 32'h0);
    drive(1'b1, 1'b1, 32'hC, 4'hF, 32'h1234_5678);
    resetn = 1'b0;
    idle(2);
    resetn = 1'b1;
    idle(6);
    for (int w = 0; w < 16; w++) drive(1'b1, 1'b0, 32'(w) << 2, 4'h0, 32'h0);
    idle(10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
